rf_param: RTL
=============

# rf_param

Parametrised successor to the team's two-read/one-write register file. It provides:
- configurable data width, depth and read-port count;
- registered synchronous reads with same-cycle write bypass and an optional hard-wired zero register;
- a per-register pending-write scoreboard for hazard detection;
- a post-reset clear sequencer, so no array reset is needed.

It sits between decode (read and issue) and writeback in the core pipeline.

## Interface
- DATA_W, 16, register width in bits
- DEPTH, 16, number of registers; power of two, at least 2; ADDR_W = $clog2(DEPTH)
- NUM_RD, 2, number of read ports; range 1 to 4
- ZERO_REG, 1, when 1, register 0 reads as 0, ignores writes and is never pending
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- rd_en  input  NUM_RD  per-port read enable
- rd_addr  input  NUM_RD*ADDR_W  packed read addresses; port i is bits [i*ADDR_W +: ADDR_W]
- rd_data  output  NUM_RD*DATA_W  packed registered read data
- rd_pend  output  NUM_RD  combinational: the addressed register has an outstanding write
- wr_en  input  1  writeback enable
- wr_addr  input  ADDR_W  writeback address
- wr_data  input  DATA_W  writeback data
- iss_en  input  1  marks iss_addr pending (an instruction issued that targets it)
- iss_addr  input  ADDR_W  issue destination
- ready  output  1  high once the clear sequence is done; inputs are ignored while low

## Operation
- **States:** CLEAR and RUN. Reset forces CLEAR, zeroes the clear counter, and clears all pend bits.
- **CLEAR:**
  - Each cycle writes 0 to mem[cnt], then increments cnt.
  - At cnt == DEPTH-1, the next state is RUN.
  - ready is the registered value (state == RUN).
  - wr_en, iss_en and rd_en are ignored; rd_data holds 0.
- **Write (RUN, wr_en):**
  - mem[wr_addr] <= wr_data.
  - If ZERO_REG and wr_addr == 0, the write is dropped.
- **Read (RUN, rd_en[i]):**
  - rd_data[i] <= mem[rd_addr[i]] at the next edge.
  - If wr_en and wr_addr == rd_addr[i] in the same cycle, wr_data is forwarded instead.
  - If ZERO_REG and rd_addr[i] == 0, rd_data[i] <= 0, overriding the bypass.
  - When rd_en[i] is low, rd_data[i] holds its value.
- **Scoreboard update, per register r, at each edge in RUN:**
  - iss_en && iss_addr == r sets pend[r].
  - Otherwise, wr_en && wr_addr == r clears pend[r].
  - When both hit the same register in the same cycle, set wins (a newer producer was issued).
  - If ZERO_REG, pend[0] is constant 0.
- **rd_pend[i]:**
  - Equals pend[rd_addr[i]] && !(wr_en && wr_addr == rd_addr[i]), because a same-cycle write is bypassed.
  - Forced to 0 while ready is low.
- **Multiple read ports** on the same address are independent and return identical data.

## Timing
- **Reset values:** rd_data all 0; ready 0; pend all 0, so rd_pend is 0; state CLEAR; cnt 0.
- **Clear duration:** ready rises at the DEPTH-th rising edge after rst_n deasserts, i.e. 16 cycles by default. Inputs are accepted from the first edge at which ready is already 1.
- **Read latency:** 1 cycle, from address at edge N-1 to rd_data valid after edge N.
- **Bypass:** write-to-read is 0 cycles. A write and a read of the same address in the same cycle return the new data. A read issued the cycle after a write sees it from the array.
- **Scoreboard timing:** iss_en at edge N makes rd_pend visible combinationally after edge N. A write at edge M clears it after M, and rd_pend is already masked during cycle M.
- **Reset mid-operation:** rst_n low immediately zeroes rd_data, ready and pend. Array contents are undefined until the clear sequence reruns; no partial state is retained.
- **Address wrap:** none; every address value is legal because DEPTH is a power of two.

## Test plan
- **Reset/clear:** assert rst_n low, release, poll ready.
  - Required: ready = 0 for exactly 16 cycles, then 1.
  - Reading any of r1 to r15 then returns 0x0000.
- **Write then read:** write r5 = 0xBEEF, then one cycle later read port 0 at r5 and port 1 at r5.
  - Required: both ports show 0xBEEF one cycle after the read.
  - Holding rd_en low afterwards keeps 0xBEEF.
- **Bypass and zero register:**
  - Same cycle, wr r3 = 0x1234 and rd r3 -> rd_data 0x1234 next cycle.
  - wr r0 = 0xFFFF, then rd r0 -> 0x0000.
- **Scoreboard set/clear:**
  - iss r7 -> rd_pend = 1 for a read of r7.
  - wr r7 = 0x00AA in a later cycle -> rd_pend = 0 during that cycle; data 0x00AA is returned.
  - iss r0 -> rd_pend stays 0.
- **Set/clear collision:** iss r9 and wr r9 = 0x5555 in the same cycle.
  - Required: pend[r9] = 1 afterwards; a read returns 0x5555.
- **Reset mid-run:** with r2 pending and rd_data = 0xBEEF, pulse rst_n low for 1 cycle.
  - Required: rd_data = 0, ready = 0 and rd_pend = 0 immediately.
  - Clear reruns for 16 cycles; r2 then reads 0x0000.

Source files
------------

// File: rtl/rf_param_if.sv
// Register-file port bundle: read ports, writeback, issue marking and ready.
// master drives requests (decode/writeback side), slave is the register file.
interface rf_param_if #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int NUM_RD = 2
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic [NUM_RD-1:0]        rd_en;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_pend;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     iss_en;
    logic [ADDR_W-1:0]        iss_addr;
    logic                     ready;

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        input  rd_data, rd_pend, ready
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        output rd_data, rd_pend, ready
    );
endinterface

// File: rtl/rf_param.sv
// Parametrised register file with registered reads, same-cycle write bypass,
// optional hard-wired zero register, pending-write scoreboard and a post-reset
// clear sequencer that zeroes the array instead of resetting it.
//
// state | meaning
// ------+---------------------------------------------------------------
// CLEAR | zeroing mem[cnt] one entry per cycle; all port inputs ignored
// RUN   | normal operation; ready high
module rf_param #(
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 16,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input logic       clk,
    input logic       rst_n,
    rf_param_if.slave bus
);
    localparam int ADDR_W = $clog2(DEPTH);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [ADDR_W-1:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0]        mem [DEPTH];
    logic [DEPTH-1:0]         pend_q, pend_d;
    logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_d;
    logic [ADDR_W-1:0]        rd_addr_v [NUM_RD];
    logic [NUM_RD-1:0]        rd_pend_v;
    logic                     run;
    logic                     wr_ok;

    assign run   = (state_q == RUN);
    // Writes to the zero register are dropped so it always reads back 0.
    assign wr_ok = run && bus.wr_en && !((ZERO_REG != 0) && (bus.wr_addr == '0));

    // Unpack read addresses and form the combinational hazard flag per port;
    // a same-cycle write to the address is bypassed, so it is not a hazard.
    for (genvar i = 0; i < NUM_RD; i++) begin : g_port
        assign rd_addr_v[i] = bus.rd_addr[i*ADDR_W +: ADDR_W];
        assign rd_pend_v[i] = run && pend_q[rd_addr_v[i]]
                              && !(bus.wr_en && (bus.wr_addr == rd_addr_v[i]));
    end

    assign bus.rd_pend = rd_pend_v;
    assign bus.rd_data = rd_data_q;
    assign bus.ready   = run;

    // Clear sequencer: walk cnt through every entry once, then hand over to RUN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == CLEAR) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                state_d = RUN;
            end
        end
    end

    // Scoreboard next value: an issue sets, a writeback clears, issue wins a tie.
    always_comb begin
        pend_d = pend_q;
        if (run) begin
            for (int r = 0; r < DEPTH; r++) begin
                if (bus.iss_en && (bus.iss_addr == ADDR_W'(r))) begin
                    pend_d[r] = 1'b1;
                end else if (bus.wr_en && (bus.wr_addr == ADDR_W'(r))) begin
                    pend_d[r] = 1'b0;
                end
            end
        end
        if (ZERO_REG != 0) begin
            pend_d[0] = 1'b0;
        end
    end

    // Read data next value: zero register first, then write bypass, then array.
    always_comb begin
        rd_data_d = rd_data_q;
        for (int i = 0; i < NUM_RD; i++) begin
            if (run && bus.rd_en[i]) begin
                if ((ZERO_REG != 0) && (rd_addr_v[i] == '0)) begin
                    rd_data_d[i*DATA_W +: DATA_W] = '0;
                end else if (bus.wr_en && (bus.wr_addr == rd_addr_v[i])) begin
                    rd_data_d[i*DATA_W +: DATA_W] = bus.wr_data;
                end else begin
                    rd_data_d[i*DATA_W +: DATA_W] = mem[rd_addr_v[i]];
                end
            end
        end
    end

    // Control state, scoreboard and read registers; all cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= CLEAR;
            cnt_q     <= '0;
            pend_q    <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Storage array has no reset; the clear sequence zeroes it after reset.
    always_ff @(posedge clk) begin
        if (!run) begin
            mem[cnt_q] <= '0;
        end else if (wr_ok) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end
endmodule
